// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Registered, parametrised ALU with {Z,N,C,V} flags, an
//                iterative shift-add multiplier and valid/ready handshakes
//                on both the operand and the result side.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_seq #(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:WIDTH-1] a,
    input  logic [0:WIDTH-1] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:WIDTH-1] result,
    output logic [3:0]       flags,
    output logic             err
);

    localparam logic [3:0] c_OP_ADD = 4'b0000;
    localparam logic [3:0] c_OP_SUB = 4'b0001;
    localparam logic [3:0] c_OP_INC = 4'b0010;
    localparam logic [3:0] c_OP_DEC = 4'b0011;
    localparam logic [3:0] c_OP_AND = 4'b0100;
    localparam logic [3:0] c_OP_OR  = 4'b0101;
    localparam logic [3:0] c_OP_XOR = 4'b0110;
    localparam logic [3:0] c_OP_NOT = 4'b0111;
    localparam logic [3:0] c_OP_SHL = 4'b1000;
    localparam logic [3:0] c_OP_SHR = 4'b1001;
    localparam logic [3:0] c_OP_ASR = 4'b1010;
    localparam logic [3:0] c_OP_MUL = 4'b1011;
    localparam logic [3:0] c_OP_CMP = 4'b1100;

    localparam logic [SHW:0] c_CNT_INIT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] c_CNT_LAST = (SHW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Operands viewed with conventional descending numbering (MSB = WIDTH-1)
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [SHW-1:0]     w_sh;
    logic [WIDTH-1:0]   w_add_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_shr;
    logic [WIDTH:0]     w_asr;
    logic               w_v_add;
    logic               w_v_sub;

    logic [WIDTH-1:0]   w_res;
    logic [WIDTH-1:0]   w_zn;
    logic               w_c;
    logic               w_v;
    logic               w_err;
    logic [3:0]         w_flags;

    logic               w_accept;
    logic               w_is_mul;
    logic [2*WIDTH-1:0] w_step_acc;
    logic [WIDTH-1:0]   w_mul_res;
    logic               w_mul_c;

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [SHW:0]       r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_flags;
    logic               r_err;
    logic               r_out_valid;

    assign w_a  = a;
    assign w_b  = b;
    assign w_sh = w_b[SHW-1:0];

    // INC/DEC reuse the adder/subtractor with a constant one as operand B
    assign w_add_b = ((opcode == c_OP_INC) || (opcode == c_OP_DEC)) ?
                     WIDTH'(1) : w_b;
    assign w_sum   = {1'b0, w_a} + {1'b0, w_add_b};
    assign w_diff  = {1'b0, w_a} - {1'b0, w_add_b};
    assign w_v_add = (w_a[WIDTH-1] == w_add_b[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != w_a[WIDTH-1]);
    assign w_v_sub = (w_a[WIDTH-1] != w_add_b[WIDTH-1]) &&
                     (w_diff[WIDTH-1] != w_a[WIDTH-1]);

    // One guard bit catches the last bit shifted out (zero for amount 0)
    assign w_shl = {1'b0, w_a} << w_sh;
    assign w_shr = {w_a, 1'b0} >> w_sh;
    assign w_asr = $signed({w_a, 1'b0}) >>> w_sh;

    assign w_is_mul = (opcode == c_OP_MUL);

    // Single-cycle operations: result, flag sources and illegal-op detect
    always_comb begin
        w_res = '0;
        w_zn  = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_err = 1'b0;
        case (opcode)
            c_OP_ADD, c_OP_INC: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = w_v_add;
            end
            c_OP_SUB, c_OP_DEC: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = w_v_sub;
            end
            c_OP_AND: w_res = w_a & w_b;
            c_OP_OR:  w_res = w_a | w_b;
            c_OP_XOR: w_res = w_a ^ w_b;
            c_OP_NOT: w_res = ~w_a;
            c_OP_SHL: begin
                w_res = w_shl[WIDTH-1:0];
                w_c   = w_shl[WIDTH];
            end
            c_OP_SHR: begin
                w_res = w_shr[WIDTH:1];
                w_c   = w_shr[0];
            end
            c_OP_ASR: begin
                w_res = w_asr[WIDTH:1];
                w_c   = w_asr[0];
            end
            c_OP_CMP: begin
                w_res = w_a;
                w_c   = w_diff[WIDTH];
                w_v   = w_v_sub;
            end
            c_OP_MUL: w_res = '0;
            default:  w_err = 1'b1;
        endcase
        // Z/N follow the result except for CMP, which reports on a-b
        w_zn = (opcode == c_OP_CMP) ? w_diff[WIDTH-1:0] : w_res;
    end

    assign w_flags = w_err ? 4'b0000 :
                     {(w_zn == '0), w_zn[WIDTH-1], w_c, w_v};

    // One shift-add step; on the final step this is the full product
    assign w_step_acc = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mul_res  = w_step_acc[WIDTH-1:0];
    assign w_mul_c    = |w_step_acc[2*WIDTH-1:WIDTH];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic and input-side handshake
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            S_IDLE: in_ready = 1'b1;
            S_BUSY: begin
                if (r_cnt == c_CNT_LAST) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                in_ready = out_ready;
                if (out_ready && !in_valid) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_accept = in_valid && in_ready;
        if (w_accept) w_state_nxt = w_is_mul ? S_BUSY : S_DONE;
    end

    // Datapath: operand capture, multiply iteration and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_flags     <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= (w_state_nxt == S_DONE);
            if (w_accept && w_is_mul) begin
                r_acc    <= '0;
                r_mcand  <= {{WIDTH{1'b0}}, w_a};
                r_mplier <= w_b;
                r_cnt    <= c_CNT_INIT;
            end else if (w_accept) begin
                r_result <= w_res;
                r_flags  <= w_flags;
                r_err    <= w_err;
            end else if (r_state == S_BUSY) begin
                r_acc    <= w_step_acc;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - c_CNT_LAST;
                if (r_cnt == c_CNT_LAST) begin
                    r_result <= w_mul_res;
                    r_flags  <= {(w_mul_res == '0), w_mul_res[WIDTH-1],
                                 w_mul_c, w_mul_c};
                    r_err    <= 1'b0;
                end
            end
        end
    end

    assign result    = r_result;
    assign flags     = r_flags;
    assign err       = r_err;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Directed self-checking bench for alu_seq (WIDTH = 16).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_seq;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [0:WIDTH-1] a;
    logic [0:WIDTH-1] b;
    logic [3:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [0:WIDTH-1] result;
    logic [3:0]       flags;
    logic             err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one op with out_ready high; check result in the following cycle
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [15:0] va, input logic [15:0] vb,
                          input logic [15:0] er, input logic [3:0] ef,
                          input logic ee);
        opcode    = op;
        a         = va;
        b         = vb;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, ".rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, ".vld"}, 32'(out_valid), 32'd1);
        check({tag, ".res"}, 32'(result), 32'(er));
        check({tag, ".flg"}, 32'(flags), 32'(ef));
        check({tag, ".err"}, 32'(err), 32'(ee));
    endtask

    initial begin
        int lat;
        bit busy_ready;
        bit spurious;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        opcode    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.vld", 32'(out_valid), 32'd0);
        check("rst.res", 32'(result), 32'd0);
        check("rst.flg", 32'(flags), 32'd0);
        check("rst.err", 32'(err), 32'd0);
        check("rst.rdy", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Arithmetic, logic and shift vectors; flags are {Z,N,C,V}
        run_op("add",    4'b0000, 16'd64,    16'd32,    16'd96,    4'b0000, 1'b0);
        run_op("addovf", 4'b0000, 16'h7FFF,  16'h0001,  16'h8000,  4'b0101, 1'b0);
        run_op("subbrw", 4'b0001, 16'd32,    16'd64,    16'hFFE0,  4'b0110, 1'b0);
        run_op("cmpeq",  4'b1100, 16'd5,     16'd5,     16'd5,     4'b1000, 1'b0);
        run_op("inc",    4'b0010, 16'hFFFF,  16'h1234,  16'h0000,  4'b1010, 1'b0);
        run_op("dec",    4'b0011, 16'h0000,  16'h1234,  16'hFFFF,  4'b0110, 1'b0);
        run_op("and",    4'b0100, 16'hF0F0,  16'hFF00,  16'hF000,  4'b0100, 1'b0);
        run_op("or",     4'b0101, 16'h0F00,  16'h00F0,  16'h0FF0,  4'b0000, 1'b0);
        run_op("xor",    4'b0110, 16'hAAAA,  16'hAAAA,  16'h0000,  4'b1000, 1'b0);
        run_op("not",    4'b0111, 16'h00FF,  16'h0000,  16'hFF00,  4'b0100, 1'b0);
        run_op("asr",    4'b1010, 16'h8004,  16'h0002,  16'hE001,  4'b0100, 1'b0);
        run_op("asr0",   4'b1010, 16'h8004,  16'h0000,  16'h8004,  4'b0100, 1'b0);
        run_op("shr",    4'b1001, 16'h8004,  16'h0012,  16'h2001,  4'b0000, 1'b0);
        run_op("shl",    4'b1000, 16'hC000,  16'h0001,  16'h8000,  4'b0110, 1'b0);
        run_op("shrc",   4'b1001, 16'h0003,  16'h0001,  16'h0001,  4'b0010, 1'b0);

        // MUL 300*300 = 0x15F90; in_valid pulses offered while busy
        opcode   = 4'b1011;
        a        = 16'd300;
        b        = 16'd300;
        in_valid = 1'b1;
        #1;
        check("mul.rdy", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        opcode     = 4'b0000;
        a          = 16'd1;
        b          = 16'd1;
        lat        = 0;
        busy_ready = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            in_valid = i[0];
            if (in_ready) busy_ready = 1'b1;
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i + 1;
                break;
            end
        end
        in_valid = 1'b0;
        check("mul.lat", 32'(lat), 32'd17);
        check("mul.busyrdy", 32'(busy_ready), 32'd0);
        check("mul.res", 32'(result), 32'h5F90);
        check("mul.flg", 32'(flags), 32'(4'b0011));
        check("mul.err", 32'(err), 32'd0);

        // Backpressure: first result held, second op waits for out_ready
        @(posedge clk); #1;
        opcode    = 4'b0000;
        a         = 16'd3;
        b         = 16'd4;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        opcode = 4'b0001;
        a      = 16'd10;
        b      = 16'd4;
        check("bp.rdy0", 32'(in_ready), 32'd0);
        check("bp.res0", 32'(result), 32'd7);
        repeat (2) @(posedge clk);
        #1;
        check("bp.vld1", 32'(out_valid), 32'd1);
        check("bp.res1", 32'(result), 32'd7);
        check("bp.rdy1", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        check("bp.rdy2", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp.vld2", 32'(out_valid), 32'd1);
        check("bp.res2", 32'(result), 32'd6);

        run_op("ill",    4'b1110, 16'h1234,  16'h5678,  16'h0000,  4'b0000, 1'b1);
        run_op("ill2",   4'b1101, 16'h0001,  16'h0001,  16'h0000,  4'b0000, 1'b1);
        run_op("post",   4'b0000, 16'h0001,  16'h0002,  16'h0003,  4'b0000, 1'b0);

        // Reset during BUSY (cycle 5 of a MUL) discards the operation
        opcode   = 4'b1011;
        a        = 16'd300;
        b        = 16'd300;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rmid.vld", 32'(out_valid), 32'd0);
        check("rmid.res", 32'(result), 32'd0);
        check("rmid.flg", 32'(flags), 32'd0);
        check("rmid.err", 32'(err), 32'd0);
        check("rmid.rdy", 32'(in_ready), 32'd1);
        rst_n    = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) spurious = 1'b1;
        end
        check("rmid.novld", 32'(spurious), 32'd0);
        run_op("radd",   4'b0000, 16'd1,     16'd1,     16'd2,     4'b0000, 1'b0);

        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
